// File: rtl/conv_addr_gen_pkg.sv
// Shared constants for the conv address generator: geometry, FSM states and
// instruction word field positions (also used by the instruction decoder).
package conv_addr_gen_pkg;

   localparam int IMG  = 28;
   localparam int FIL  = 3;
   localparam int OUT  = IMG - FIL + 1;
   localparam int M_AW = 10;
   localparam int F_AW = 3;

   localparam int INSTR_W = 32;
   localparam int OPC_W   = 7;
   localparam int FUNC_W  = 2;

   localparam int SRC1_LSB = 22;
   localparam int SRC2_LSB = 19;
   localparam int DEST_LSB = 9;
   localparam int FUNC_LSB = 7;
   localparam int OPC_LSB  = 0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/conv_addr_gen_win.sv
// win_counter: row/col raster counter over an N x N output grid, col inner.
module win_counter
   import conv_addr_gen_pkg::*;
#(
   parameter int unsigned N  = OUT,
   parameter int unsigned CW = $clog2(N)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          clear,
   input  logic          advance,
   output logic [CW-1:0] row,
   output logic [CW-1:0] col,
   output logic          last
);

   localparam logic [CW-1:0] LAST = CW'(N - 1);

   assign last = (row == LAST) && (col == LAST);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         row <= '0;
         col <= '0;
      end else if (clear) begin
         row <= '0;
         col <= '0;
      end else if (advance) begin
         if (col == LAST) begin
            col <= '0;
            row <= (row == LAST) ? '0 : row + 1'b1;
         end else begin
            col <= col + 1'b1;
         end
      end
   end

endmodule

// File: rtl/conv_addr_gen.sv
// Generates one conv instruction word per output position of a layer pass,
// with a valid/ready handshake toward the fetch stage.
module conv_addr_gen
   import conv_addr_gen_pkg::*;
#(
   parameter int IMG  = conv_addr_gen_pkg::IMG,
   parameter int FIL  = conv_addr_gen_pkg::FIL,
   parameter int M_AW = conv_addr_gen_pkg::M_AW,
   parameter int F_AW = conv_addr_gen_pkg::F_AW
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            start,
   input  logic            abort,
   input  logic [6:0]      opcode_in,
   input  logic [1:0]      func_in,
   input  logic [M_AW-1:0] img_base,
   input  logic [M_AW-1:0] dst_base,
   input  logic [F_AW-1:0] fil_sel,
   output logic [31:0]     instr_out,
   output logic            out_valid,
   input  logic            out_ready,
   output logic            busy,
   output logic            done,
   output logic [9:0]      issued
);

   localparam int OSIDE = IMG - FIL + 1;
   localparam int RC_W  = $clog2(OSIDE);
   localparam logic [M_AW-1:0] IMG_M = M_AW'(IMG);
   localparam logic [M_AW-1:0] OUT_M = M_AW'(OSIDE);

   state_t            state;
   logic [M_AW-1:0]   img_q, dst_q;
   logic [F_AW-1:0]   fil_q;
   logic [FUNC_W-1:0] func_q;
   logic [OPC_W-1:0]  opc_q;

   logic [RC_W-1:0]   row, col;
   logic              last;
   logic              xfer, advance, clear;
   logic [M_AW-1:0]   row_m, col_m, src1, dest;

   // abort beats a coincident transfer: counters and issued stay put
   assign xfer    = (state == RUN) && out_valid && out_ready;
   assign advance = xfer && !abort;
   assign clear   = (state == IDLE) && start;

   win_counter #(.N(OSIDE), .CW(RC_W)) u_win (
      .clock   (clock),
      .reset   (reset),
      .clear   (clear),
      .advance (advance),
      .row     (row),
      .col     (col),
      .last    (last)
   );

   assign row_m = M_AW'(row);
   assign col_m = M_AW'(col);
   assign src1  = img_q + row_m * IMG_M + col_m;
   assign dest  = dst_q + row_m * OUT_M + col_m;

   always_comb begin
      instr_out = '0;
      instr_out[SRC1_LSB +: M_AW]   = src1;
      instr_out[SRC2_LSB +: F_AW]   = fil_q;
      instr_out[DEST_LSB +: M_AW]   = dest;
      instr_out[FUNC_LSB +: FUNC_W] = func_q;
      instr_out[OPC_LSB  +: OPC_W]  = opc_q;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         issued    <= '0;
         img_q     <= '0;
         dst_q     <= '0;
         fil_q     <= '0;
         func_q    <= '0;
         opc_q     <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  img_q     <= img_base;
                  dst_q     <= dst_base;
                  fil_q     <= fil_sel;
                  func_q    <= func_in;
                  opc_q     <= opcode_in;
                  issued    <= '0;
                  out_valid <= 1'b1;
                  busy      <= 1'b1;
                  state     <= RUN;
               end
            end
            RUN: begin
               if (abort) begin
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end else if (xfer) begin
                  issued <= issued + 1'b1;
                  if (last) begin
                     out_valid <= 1'b0;
                     busy      <= 1'b0;
                     done      <= 1'b1;
                     state     <= DONE;
                  end
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_conv_addr_gen.sv
// Scoreboard bench for conv_addr_gen: expected words are queued at start and
// popped on every transfer observed on the falling clock edge.
module tb_conv_addr_gen;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [6:0]  opcode_in = '0;
   logic [1:0]  func_in = '0;
   logic [9:0]  img_base = '0;
   logic [9:0]  dst_base = '0;
   logic [2:0]  fil_sel = '0;
   logic [31:0] instr_out;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic        busy;
   logic        done;
   logic [9:0]  issued;

   int n_checks = 0;
   int n_errors = 0;
   int pass_pops = 0;
   logic [31:0] exp_q[$];
   logic        pend_done = 1'b0;
   logic        prev_stall = 1'b0;
   logic [31:0] prev_word = '0;

   always #5 clock = ~clock;

   conv_addr_gen dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .abort     (abort),
      .opcode_in (opcode_in),
      .func_in   (func_in),
      .img_base  (img_base),
      .dst_base  (dst_base),
      .fil_sel   (fil_sel),
      .instr_out (instr_out),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy),
      .done      (done),
      .issued    (issued)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] exp_word(input int r, input int c,
                                            input logic [9:0] ib, input logic [9:0] db,
                                            input logic [2:0] fs, input logic [1:0] fn,
                                            input logic [6:0] op);
      logic [9:0] s1, d;
      s1 = ib + 10'(r * 28 + c);
      d  = db + 10'(r * 26 + c);
      return {s1, fs, d, fn, op};
   endfunction

   // Transfer monitor: pops and compares, checks hold-while-stalled and done timing.
   always @(negedge clock) begin
      check_val("done", 32'(done), 32'(pend_done));
      pend_done = 1'b0;
      if (prev_stall && reset) begin
         check_val("hold_valid", 32'(out_valid), 32'd1);
         check_val("hold_word", instr_out, prev_word);
      end
      if (reset && busy)
         check_val("issued_run", 32'(issued), 32'(pass_pops));
      if (out_valid && out_ready && !abort && reset) begin
         if (exp_q.size() == 0) begin
            check_val("sb_nonempty", 32'(exp_q.size()), 32'd1);
         end else begin
            check_val("word", instr_out, exp_q.pop_front());
            pass_pops++;
            if (exp_q.size() == 0) pend_done = 1'b1;
         end
      end
      prev_stall = out_valid && !out_ready && !abort && reset;
      prev_word  = instr_out;
   end

   // Called at posedge+1; returns at posedge+1 of the accept edge.
   task automatic start_pass(input logic [9:0] ib, input logic [9:0] db, input logic [2:0] fs,
                             input logic [1:0] fn, input logic [6:0] op);
      img_base  = ib;
      dst_base  = db;
      fil_sel   = fs;
      func_in   = fn;
      opcode_in = op;
      for (int r = 0; r < 26; r++)
         for (int c = 0; c < 26; c++)
            exp_q.push_back(exp_word(r, c, ib, db, fs, fn, op));
      pass_pops = 0;
      start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      img_base  = 10'($urandom);
      dst_base  = 10'($urandom);
      fil_sel   = 3'($urandom);
      func_in   = 2'($urandom);
      opcode_in = 7'($urandom);
   endtask

   task automatic wait_done(input int budget, input bit rnd_ready, input bit poke_start,
                            output int cycles);
      bit seen;
      seen   = 1'b0;
      cycles = 0;
      while (!seen && cycles < budget) begin
         @(negedge clock);
         cycles++;
         if (done) seen = 1'b1;
         else if (rnd_ready) begin
            @(posedge clock);
            #1 out_ready = 1'($urandom_range(0, 1));
         end
      end
      check_val("done_seen", 32'(seen), 32'd1);
      check_val("done_valid", 32'(out_valid), 32'd0);
      check_val("done_busy", 32'(busy), 32'd0);
      check_val("issued_final", 32'(issued), 32'd676);
      check_val("sb_drained", 32'(exp_q.size()), 32'd0);
      if (poke_start) start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      out_ready = 1'b1;
      if (poke_start) begin
         @(negedge clock);
         check_val("after_done_valid", 32'(out_valid), 32'd0);
         check_val("after_done_busy", 32'(busy), 32'd0);
         @(posedge clock);
         #1;
      end
   endtask

   int cyc;

   initial begin
      repeat (2) @(negedge clock);
      check_val("rst_valid", 32'(out_valid), 32'd0);
      check_val("rst_busy", 32'(busy), 32'd0);
      check_val("rst_done", 32'(done), 32'd0);
      check_val("rst_issued", 32'(issued), 32'd0);
      check_val("rst_instr", instr_out, 32'd0);
      @(posedge clock);
      #1 reset = 1'b1;
      @(posedge clock);
      #1;

      // base pass, no backpressure: 676 words back to back
      start_pass(10'd0, 10'd0, 3'd2, 2'd1, 7'h13);
      wait_done(2000, 1'b0, 1'b0, cyc);
      check_val("base_cycles", 32'(cyc), 32'd677);

      // wrap at 1024, start pulses during RUN and DONE
      start_pass(10'd1000, 10'd40, 3'd5, 2'd2, 7'h2b);
      repeat (10) @(posedge clock);
      #1 start = 1'b1;
      img_base = 10'd3;
      @(posedge clock);
      #1 start = 1'b0;
      repeat (300) @(posedge clock);
      #1 start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      wait_done(2000, 1'b0, 1'b1, cyc);

      // random backpressure
      start_pass(10'd77, 10'd500, 3'd7, 2'd3, 7'h55);
      wait_done(6000, 1'b1, 1'b0, cyc);

      // abort coincident with the 101st transfer
      start_pass(10'd12, 10'd34, 3'd1, 2'd0, 7'h0f);
      repeat (100) @(posedge clock);
      #1 abort = 1'b1;
      @(posedge clock);
      #1 abort = 1'b0;
      exp_q.delete();
      @(negedge clock);
      check_val("abort_valid", 32'(out_valid), 32'd0);
      check_val("abort_busy", 32'(busy), 32'd0);
      check_val("abort_issued", 32'(issued), 32'd100);
      check_val("abort_pops", 32'(pass_pops), 32'd100);
      #1 abort = 1'b1;
      repeat (5) @(negedge clock);
      check_val("abort_idle_issued", 32'(issued), 32'd100);
      check_val("abort_idle_valid", 32'(out_valid), 32'd0);
      @(posedge clock);
      #1 abort = 1'b0;

      // asynchronous reset mid-pass, then a fresh pass from (0,0)
      start_pass(10'd200, 10'd300, 3'd3, 2'd1, 7'h21);
      repeat (40) @(posedge clock);
      #2 reset = 1'b0;
      exp_q.delete();
      #1;
      check_val("arst_valid", 32'(out_valid), 32'd0);
      check_val("arst_busy", 32'(busy), 32'd0);
      check_val("arst_issued", 32'(issued), 32'd0);
      check_val("arst_instr", instr_out, 32'd0);
      repeat (3) @(posedge clock);
      #1 reset = 1'b1;
      repeat (3) @(negedge clock);
      check_val("post_rst_valid", 32'(out_valid), 32'd0);
      check_val("post_rst_busy", 32'(busy), 32'd0);
      @(posedge clock);
      #1;
      start_pass(10'd200, 10'd300, 3'd3, 2'd1, 7'h21);
      wait_done(2000, 1'b0, 1'b0, cyc);
      check_val("restart_cycles", 32'(cyc), 32'd677);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
